ski_reduce_engine: RTL

- Sequential, parametrised successor to the combinational SKI step logic.
- Performs repeated graph reduction of S/K/I combinator expressions held in an external node heap.
- Walks the application spine with an internal stack and rewrites redexes in place through a single-port memory handshake.
- Stops at weak head normal form, on a step limit, or on an error.
- Sits between the host/loader (which provides start, root and heap bounds) and the heap RAM.

---
 rtl/ski_pkg.sv | 66 ++++++
 rtl/ski_reduce_engine_if.sv | 19 +
 rtl/ski_spine_stack.sv | 63 ++++++
 rtl/ski_reduce_engine.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ski_pkg.sv
// Shared definitions for the SKI reduction engine: node tags, error codes,
// FSM encoding and node word helpers. The helpers work on a fixed maximal
// width so that any ADDR_W up to ADDR_MAX can use them; callers size-cast.
package ski_pkg;

    localparam logic [2:0] TAG_APP = 3'd0;
    localparam logic [2:0] TAG_S   = 3'd1;
    localparam logic [2:0] TAG_K   = 3'd2;
    localparam logic [2:0] TAG_I   = 3'd3;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_STACK = 2'b01;
    localparam logic [1:0] ERR_HEAP  = 2'b10;
    localparam logic [1:0] ERR_TAG   = 2'b11;

    localparam int ADDR_MAX = 64;
    localparam int NODE_MAX = 3 + 2 * ADDR_MAX;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISPATCH,
        ST_RD_ARG,
        ST_WR_NODE,
        ST_S_WR0,
        ST_S_WR1,
        ST_S_WR2
    } state_t;

    function automatic int node_w(int aw);
        return 3 + 2 * aw;
    endfunction

    // Fields are expected to be already confined to aw bits.
    function automatic logic [NODE_MAX-1:0] node_pack(logic [2:0] tag,
                                                      logic [ADDR_MAX-1:0] left,
                                                      logic [ADDR_MAX-1:0] right,
                                                      int aw);
        logic [NODE_MAX-1:0] n;
        n = NODE_MAX'(right);
        n = n | (NODE_MAX'(left) << aw);
        n = n | (NODE_MAX'(tag) << (2 * aw));
        return n;
    endfunction

    function automatic logic [2:0] node_tag(logic [NODE_MAX-1:0] n, int aw);
        logic [NODE_MAX-1:0] t;
        t = n >> (2 * aw);
        return t[2:0];
    endfunction

    function automatic logic [ADDR_MAX-1:0] node_left(logic [NODE_MAX-1:0] n, int aw);
        logic [NODE_MAX-1:0] t;
        logic [ADDR_MAX-1:0] m;
        t = n >> aw;
        m = {ADDR_MAX{1'b1}} >> (ADDR_MAX - aw);
        return t[ADDR_MAX-1:0] & m;
    endfunction

    function automatic logic [ADDR_MAX-1:0] node_right(logic [NODE_MAX-1:0] n, int aw);
        logic [ADDR_MAX-1:0] m;
        m = {ADDR_MAX{1'b1}} >> (ADDR_MAX - aw);
        return n[ADDR_MAX-1:0] & m;
    endfunction

endpackage

// File: rtl/ski_reduce_engine_if.sv
// Single-port heap memory handshake between the reduction engine (master)
// and the heap RAM (slave). Read data is valid in the cycle of mem_ack.
interface ski_reduce_engine_if import ski_pkg::*; #(
    parameter int ADDR_W = 30
);
    localparam int NODE_W = node_w(ADDR_W);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NODE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [NODE_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/ski_spine_stack.sv
// Register LIFO holding the application spine: each entry is the address of
// an APP node and its right (argument) child. Entries 0..2 below the top are
// visible combinationally; pops remove 1..3 entries at once.
module ski_spine_stack import ski_pkg::*; #(
    parameter  int ADDR_W = 30,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [ADDR_W-1:0] push_arg,
    input  logic [1:0]        pop_n,
    output logic [ADDR_W-1:0] peek_addr [3],
    output logic [ADDR_W-1:0] peek_arg  [3],
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] arg_q  [DEPTH];
    logic [CNT_W-1:0]  sp_q;
    logic [IDX_W-1:0]  idx;

    assign count = sp_q;
    assign full  = (sp_q == CNT_W'(DEPTH));
    assign empty = (sp_q == '0);

    // Peek the top three entries; values below the fill level are don't-care.
    always_comb begin
        idx = '0;
        for (int k = 0; k < 3; k++) begin
            idx          = IDX_W'(sp_q - CNT_W'(k + 1));
            peek_addr[k] = addr_q[idx];
            peek_arg[k]  = arg_q[idx];
        end
    end

    // Entry storage needs no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            addr_q[sp_q[IDX_W-1:0]] <= push_addr;
            arg_q[sp_q[IDX_W-1:0]]  <= push_arg;
        end
    end

    // Stack pointer: clear on a new run, then push or multi-pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (clear) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + CNT_W'(1);
        end else if (pop_n != 2'd0) begin
            sp_q <= sp_q - CNT_W'(pop_n);
        end
    end
endmodule

// File: rtl/ski_reduce_engine.sv
// SKI graph reduction engine: unwinds the application spine onto a stack,
// rewrites I/K/S redexes in place in the heap and stops at weak head normal
// form, at the step limit or on an error. The redex node is always written
// last so the heap stays consistent if the run is abandoned.
module ski_reduce_engine import ski_pkg::*; #(
    parameter int ADDR_W      = 30,
    parameter int STACK_DEPTH = 16,
    parameter int COUNT_W     = 32
) (
    input  logic               system1000,
    input  logic               system1000_rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  root,
    input  logic [ADDR_W-1:0]  free_base,
    input  logic [ADDR_W-1:0]  heap_limit,
    input  logic [COUNT_W-1:0] step_limit,
    ski_reduce_engine_if.master mem,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err_code,
    output logic [2:0]         head_tag,
    output logic [COUNT_W-1:0] steps
);
    localparam int NODE_W = node_w(ADDR_W);
    localparam int CNT_W  = $clog2(STACK_DEPTH) + 1;

    state_t             state_q, state_n;
    logic [ADDR_W-1:0]  cur_q, free_q, x_q, f_q, g_q, tgt_q;
    logic [NODE_W-1:0]  node_q;
    logic [2:0]         tag_w;
    logic [ADDR_W-1:0]  left_w, right_w, free_p1;
    logic               heap_ovf, limit_hit;
    logic [COUNT_W-1:0] steps_inc;

    logic               req, we, push, clear, fin;
    logic [ADDR_W-1:0]  addr;
    logic [NODE_W-1:0]  wdata;
    logic [1:0]         pop_n, fin_err;
    logic [2:0]         fin_tag;

    logic [ADDR_W-1:0]  pk_addr [3];
    logic [ADDR_W-1:0]  pk_arg  [3];
    logic [CNT_W-1:0]   count;
    logic               full, empty;

    assign tag_w     = node_tag(NODE_MAX'(node_q), ADDR_W);
    assign left_w    = ADDR_W'(node_left(NODE_MAX'(node_q), ADDR_W));
    assign right_w   = ADDR_W'(node_right(NODE_MAX'(node_q), ADDR_W));
    assign free_p1   = free_q + ADDR_W'(1);
    // One extra bit so a free pointer near the top of the space cannot wrap.
    assign heap_ovf  = ({1'b0, free_q} + (ADDR_W + 1)'(2)) > {1'b0, heap_limit};
    assign steps_inc = steps + COUNT_W'(1);
    assign limit_hit = (step_limit != '0) && (steps_inc == step_limit);

    assign busy          = (state_q != ST_IDLE);
    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;

    ski_spine_stack #(.ADDR_W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (system1000),
        .rst       (system1000_rst),
        .clear     (clear),
        .push      (push),
        .push_addr (cur_q),
        .push_arg  (right_w),
        .pop_n     (pop_n),
        .peek_addr (pk_addr),
        .peek_arg  (pk_arg),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // State register.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) state_q <= ST_IDLE;
        else                state_q <= state_n;
    end

    // Next state, memory request and stack control.
    always_comb begin
        state_n = state_q;
        req     = 1'b0;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        push    = 1'b0;
        pop_n   = 2'd0;
        clear   = 1'b0;
        fin     = 1'b0;
        fin_err = ERR_OK;
        fin_tag = TAG_APP;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                req  = 1'b1;
                addr = cur_q;
                if (mem.mem_ack) state_n = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                case (tag_w)
                    TAG_APP: begin
                        if (full) begin
                            fin     = 1'b1;
                            fin_err = ERR_STACK;
                        end else begin
                            push    = 1'b1;
                            state_n = ST_FETCH;
                        end
                    end
                    TAG_I: begin
                        if (!empty) begin
                            pop_n   = 2'd1;
                            state_n = ST_RD_ARG;
                        end else begin
                            fin     = 1'b1;
                            fin_tag = TAG_I;
                        end
                    end
                    TAG_K: begin
                        if (count >= CNT_W'(2)) begin
                            pop_n   = 2'd2;
                            state_n = ST_RD_ARG;
                        end else begin
                            fin     = 1'b1;
                            fin_tag = TAG_K;
                        end
                    end
                    TAG_S: begin
                        fin_tag = TAG_S;
                        if (count < CNT_W'(3)) begin
                            fin = 1'b1;
                        end else if (heap_ovf) begin
                            fin     = 1'b1;
                            fin_err = ERR_HEAP;
                        end else begin
                            pop_n   = 2'd3;
                            state_n = ST_S_WR0;
                        end
                    end
                    default: begin
                        fin     = 1'b1;
                        fin_err = ERR_TAG;
                        fin_tag = tag_w;
                    end
                endcase
            end
            ST_RD_ARG: begin
                req  = 1'b1;
                addr = x_q;
                if (mem.mem_ack) state_n = ST_WR_NODE;
            end
            ST_WR_NODE, ST_S_WR2: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = tgt_q;
                wdata = (state_q == ST_WR_NODE) ? node_q :
                        NODE_W'(node_pack(TAG_APP, ADDR_MAX'(free_q), ADDR_MAX'(free_p1), ADDR_W));
                if (mem.mem_ack) begin
                    if (limit_hit) fin = 1'b1;
                    else           state_n = ST_FETCH;
                end
            end
            ST_S_WR0: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = free_q;
                wdata = NODE_W'(node_pack(TAG_APP, ADDR_MAX'(f_q), ADDR_MAX'(x_q), ADDR_W));
                if (mem.mem_ack) state_n = ST_S_WR1;
            end
            ST_S_WR1: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = free_p1;
                wdata = NODE_W'(node_pack(TAG_APP, ADDR_MAX'(g_q), ADDR_MAX'(x_q), ADDR_W));
                if (mem.mem_ack) state_n = ST_S_WR2;
            end
            default: state_n = ST_IDLE;
        endcase
        if (fin) state_n = ST_IDLE;
    end

    // Datapath: run setup, node latching, redex operand capture, results.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            cur_q    <= '0;
            free_q   <= '0;
            x_q      <= '0;
            f_q      <= '0;
            g_q      <= '0;
            tgt_q    <= '0;
            node_q   <= '0;
            steps    <= '0;
            err_code <= ERR_OK;
            head_tag <= TAG_APP;
            done     <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                err_code <= fin_err;
                head_tag <= fin_tag;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_q    <= root;
                        free_q   <= free_base;
                        steps    <= '0;
                        err_code <= ERR_OK;
                        head_tag <= TAG_APP;
                    end
                end
                ST_FETCH, ST_RD_ARG: begin
                    if (mem.mem_ack) node_q <= mem.mem_rdata;
                end
                ST_DISPATCH: begin
                    case (tag_w)
                        TAG_APP: if (!full) cur_q <= left_w;
                        TAG_I: begin
                            x_q   <= pk_arg[0];
                            tgt_q <= pk_addr[0];
                        end
                        TAG_K: begin
                            x_q   <= pk_arg[0];
                            tgt_q <= pk_addr[1];
                        end
                        TAG_S: begin
                            f_q   <= pk_arg[0];
                            g_q   <= pk_arg[1];
                            x_q   <= pk_arg[2];
                            tgt_q <= pk_addr[2];
                        end
                        default: ;
                    endcase
                end
                ST_WR_NODE: begin
                    if (mem.mem_ack) begin
                        steps <= steps_inc;
                        cur_q <= tgt_q;
                    end
                end
                ST_S_WR2: begin
                    if (mem.mem_ack) begin
                        steps  <= steps_inc;
                        cur_q  <= tgt_q;
                        free_q <= free_q + ADDR_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
